mdu_seq: RTL
============

# mdu_seq

Sequential 32-bit unsigned multiply/divide unit for the CPU datapath. It sits directly upstream of the shared 32-bit adder (X + Y + Sub, no carry out) and drives that adder's operands. It consumes the sum once per cycle for 32 iterations and produces a 64-bit product, or a quotient/remainder pair, in HI/LO. A start/busy/done handshake lets the control unit stall while the unit runs.

## Interface
- WIDTH, 32, operand width; the iteration count equals WIDTH.
- clk  input  1  clock; all registers update on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- op  input  1  0 = MULTU, 1 = DIVU.
- A  input  32  multiplicand / dividend; latched on accept.
- B  input  32  multiplier / divisor; latched on accept.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; hi/lo are valid from this cycle.
- hi  output  32  product[63:32] or remainder.
- lo  output  32  product[31:0] or quotient.
- add_x  output  32  adder X operand (combinational from state).
- add_y  output  32  adder Y operand.
- add_sub  output  1  adder carry-in.
- add_s  input  32  adder sum, returned in the same cycle.

## Operation
- States:
  - IDLE: on start, go to RUN.
  - RUN: 32 cycles, tracked by a 5-bit counter cnt; on cnt == 31, go to DONE.
  - DONE: one cycle. On start, go to RUN; otherwise go to IDLE.
- On accept, latch op, the operand registers and cnt = 0.
- Working registers: P (32-bit), Q (32-bit), M (32-bit).
- Carry out is recovered internally: c = maj(add_x[31], add_y[31], add_s[31] ^ add_x[31] ^ add_y[31]).
- MULTU:
  - Accept: P = 0, Q = B, M = A.
  - Each RUN cycle drives add_x = P, add_y = Q[0] ? M : 0, add_sub = 0.
  - Then {P, Q} = {c, add_s, Q} >> 1, which is 65 bits shifted right by 1.
- DIVU (restoring):
  - Accept: P = 0, Q = A, M = B.
  - Each RUN cycle sets t = {P[30:0], Q[31]} and drives add_x = t, add_y = ~M, add_sub = 1.
  - If P[31] | c: P = add_s and Q = {Q[30:0], 1}.
  - Otherwise: P = t and Q = {Q[30:0], 0}.
- Divide by zero is not special-cased. The algorithm itself yields lo = 0xFFFFFFFF and hi = A.
- On the RUN→DONE edge, hi = P and lo = Q. hi/lo hold their value until the next completion.
- In IDLE and DONE the adder outputs are 0, 0, 0.
- start in RUN is ignored; it is neither queued nor restarts the operation.
- A and B changing after accept have no effect.

## Timing
- Reset values: state IDLE, busy 0, done 0, hi 0, lo 0, cnt 0, P/Q/M 0, add_x 0, add_y 0, add_sub 0.
- Accept edge t0. RUN iterations occur on edges t1..t32.
- busy is high from just after t0 until t32.
- done is high for the cycle between t32 and t33.
- Latency from accept edge to done: 33 cycles.
- Back-to-back operation: start asserted during DONE is accepted at t33. busy rises again with no idle gap, giving 33 cycles per operation.
- Reset asserted mid-RUN returns the block to IDLE immediately.
  - hi/lo are cleared to 0.
  - done is never produced for the aborted operation.
- The adder path is combinational within one cycle. The add_x → add_s → register path must meet a single clock period.

## Test plan
- Multiply 7 × 6: start with op = 0 → done on the 33rd cycle after accept, hi = 0x00000000, lo = 0x0000002A; busy high for exactly 32 cycles.
- Multiply 0xFFFFFFFF × 0xFFFFFFFF (exercises the carry-out path) → hi = 0xFFFFFFFE, lo = 0x00000001.
- Divide 100 / 7 with op = 1 → lo = 14, hi = 2. Divide 0x80000000 / 3 → lo = 0x2AAAAAAA, hi = 2.
- Divide 5 / 0 → lo = 0xFFFFFFFF, hi = 5, with normal 33-cycle latency.
- Hold start high continuously for MULTU 3 × 5 then DIVU 9 / 4:
  - start pulses in RUN are ignored.
  - The second operation is accepted in the DONE cycle.
  - Results are lo = 15, then lo = 2 and hi = 1, with 33 cycles per operation.
- Assert rst at RUN cycle 10 of 0x1234 × 0x10 → outputs clear immediately and no done is seen. A subsequent 2 × 3 gives lo = 6.

Source files
------------

// File: rtl/mdu_seq.sv
// mdu_seq: sequential unsigned multiply/divide unit.
// Drives the shared datapath adder (X + Y + Sub) one iteration per cycle
// for WIDTH cycles: shift-add for MULTU, restoring division for DIVU.
// Results land in hi/lo together with a one-cycle done pulse.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic             add_sub,
  input  logic [WIDTH-1:0] add_s
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             op_r;   // 0 = MULTU, 1 = DIVU
  logic [WIDTH-1:0] p;      // high half / partial remainder
  logic [WIDTH-1:0] q;      // multiplier / dividend-quotient
  logic [WIDTH-1:0] m;      // multiplicand / divisor

  logic [WIDTH-1:0] t;      // divide trial value: {P, Q} shifted left by one
  logic             carry;  // adder carry out, rebuilt from the MSBs
  logic             s_in;   // carry into bit WIDTH-1 of the adder
  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] q_next;

  assign t = {p[WIDTH-2:0], q[WIDTH-1]};

  // The external adder has no carry out; the carry into the top bit is
  // sum ^ x ^ y there, and the carry out is the majority of the three.
  assign s_in  = add_s[WIDTH-1] ^ add_x[WIDTH-1] ^ add_y[WIDTH-1];
  assign carry = (add_x[WIDTH-1] & add_y[WIDTH-1]) |
                 (add_x[WIDTH-1] & s_in) |
                 (add_y[WIDTH-1] & s_in);

  // Adder operand selection; the adder is idle (all zero) outside RUN.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    add_x   = '0;
    add_y   = '0;
    add_sub = 1'b0;
    if (state == RUN) begin
      if (!op_r) begin
        add_x = p;
        add_y = q[0] ? m : '0;
      end else begin
        add_x   = t;
        add_y   = ~m;
        add_sub = 1'b1;
      end
    end
  end

  // Next working-register values for one iteration.
  always_comb begin
    p_next = p;
    q_next = q;
    if (!op_r) begin
      // {carry, sum, Q} shifted right by one.
      p_next = {carry, add_s[WIDTH-1:1]};
      q_next = {add_s[0], q[WIDTH-1:1]};
    end else if (p[WIDTH-1] | carry) begin
      // Trial subtraction did not borrow: keep the difference.
      p_next = add_s;
      q_next = {q[WIDTH-2:0], 1'b1};
    end else begin
      // Borrow: restore the shifted remainder.
      p_next = t;
      q_next = {q[WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM, working registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      op_r  <= 1'b0;
      p     <= '0;
      q     <= '0;
      m     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            op_r  <= op;
            cnt   <= '0;
            p     <= '0;
            q     <= op ? A : B;
            m     <= op ? B : A;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          p   <= p_next;
          q   <= q_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            hi    <= p_next;
            lo    <= q_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
